// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared types and constants for the register-file dump controller.
package regfile_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HDR,
        ST_SEL,
        ST_SEND,
        ST_DONE
    } dump_state_e;

    // One header word followed by r0..r31.
    localparam int DUMP_WORDS = 33;

    // Index carried by the header word.
    localparam logic [5:0] HDR_IDX = 6'd0;

    // Index carried by the r31 word, which is the last word of a dump.
    localparam logic [5:0] LAST_IDX = 6'(DUMP_WORDS - 1);

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump controller: freezes the CPU on halt PC, manual start or
// cycle timeout, then streams a PC header and r0..r31 over valid/ready.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_PC    = 32'h0000_0080,
    parameter int          MAX_CYCLES = 1000,
    parameter int          CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc,
    input  logic        start,
    input  logic        rearm,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        cpu_freeze,
    output logic [31:0] dump_data,
    output logic [5:0]  dump_idx,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        dump_last,
    output logic        done,
    output logic        timed_out
);

    // A limit the counter cannot represent disables the timeout entirely;
    // the counter saturates instead of wrapping, so it can never match.
    localparam bit TIMEOUT_EN = (MAX_CYCLES >= 1) &&
                                (64'(MAX_CYCLES) <= ((64'd1 << CNT_W) - 64'd1));
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_EN ? MAX_CYCLES - 1 : 0);

    dump_state_e      state_q;
    dump_state_e      state_d;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] cycle_cnt_d;

    logic [4:0]  reg_sel_d;
    logic        cpu_freeze_d;
    logic [31:0] dump_data_d;
    logic [5:0]  dump_idx_d;
    logic        dump_valid_d;
    logic        dump_last_d;
    logic        done_d;
    logic        timed_out_d;

    logic        pc_hit;
    logic        timeout_hit;
    logic        handshake;
    logic [5:0]  next_word_idx;

    assign pc_hit        = (pc == HALT_PC);
    assign timeout_hit   = TIMEOUT_EN && (cycle_cnt == TIMEOUT_CNT);
    assign handshake     = dump_valid && dump_ready;
    assign next_word_idx = {1'b0, reg_sel} + 6'd1;

    // State, counter and every registered output update together here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_RUN;
            cycle_cnt  <= '0;
            reg_sel    <= '0;
            cpu_freeze <= 1'b0;
            dump_data  <= '0;
            dump_idx   <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_cnt  <= cycle_cnt_d;
            reg_sel    <= reg_sel_d;
            cpu_freeze <= cpu_freeze_d;
            dump_data  <= dump_data_d;
            dump_idx   <= dump_idx_d;
            dump_valid <= dump_valid_d;
            dump_last  <= dump_last_d;
            done       <= done_d;
            timed_out  <= timed_out_d;
        end
    end

    // Next-state and next-output decode; everything holds unless a state acts.
    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt;
        reg_sel_d    = reg_sel;
        cpu_freeze_d = cpu_freeze;
        dump_data_d  = dump_data;
        dump_idx_d   = dump_idx;
        dump_valid_d = dump_valid;
        dump_last_d  = dump_last;
        done_d       = done;
        timed_out_d  = timed_out;

        case (state_q)
            ST_RUN: begin
                if (cycle_cnt != '1) begin
                    cycle_cnt_d = cycle_cnt + CNT_W'(1);
                end
                if (pc_hit || start || timeout_hit) begin
                    cpu_freeze_d = 1'b1;
                    dump_data_d  = pc;
                    dump_idx_d   = HDR_IDX;
                    dump_valid_d = 1'b1;
                    dump_last_d  = 1'b0;
                    timed_out_d  = !pc_hit && !start;
                    state_d      = ST_HDR;
                end
            end
            ST_HDR: begin
                if (handshake) begin
                    dump_valid_d = 1'b0;
                    reg_sel_d    = '0;
                    state_d      = ST_SEL;
                end
            end
            ST_SEL: begin
                dump_data_d  = (reg_sel == 5'd0) ? 32'd0 : reg_data;
                dump_idx_d   = next_word_idx;
                dump_last_d  = (next_word_idx == LAST_IDX);
                dump_valid_d = 1'b1;
                state_d      = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    dump_valid_d = 1'b0;
                    if (dump_last) begin
                        dump_last_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        reg_sel_d = reg_sel + 5'd1;
                        state_d   = ST_SEL;
                    end
                end
            end
            ST_DONE: begin
                if (rearm) begin
                    done_d       = 1'b0;
                    timed_out_d  = 1'b0;
                    cpu_freeze_d = 1'b0;
                    cycle_cnt_d  = '0;
                    state_d      = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: a transaction-level model of the
// dump stream plus directed scenarios with literal expectations.
module tb_regfile_dump_ctrl;

    localparam logic [31:0] HALT = 32'h0000_0080;
    localparam int          MAXC = 1000;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  idx;
        logic        last;
    } word_t;

    logic        clk;
    logic        rstn;
    logic [31:0] pc;
    logic        start;
    logic        rearm;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        cpu_freeze;
    logic [31:0] dump_data;
    logic [5:0]  dump_idx;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_last;
    logic        done;
    logic        timed_out;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state
    word_t       exp_q[$];
    word_t       exp_w;
    bit          m_run = 1'b1;
    bit          m_freeze = 1'b0;
    bit          m_done = 1'b0;
    bit          m_to = 1'b0;
    bit          was_done;
    bit          trig;
    int          m_cnt = 0;
    int          cyc = 0;
    int          trig_cycle = 0;
    int          done_cycle = 0;
    int          cnt0_cycle = 0;
    int          hs_count = 0;
    bit          prev_stall = 1'b0;
    logic [39:0] prev_word = '0;
    logic [31:0] captured [64];
    bit          rand_ready = 1'b0;

    regfile_dump_ctrl #(
        .HALT_PC    (HALT),
        .MAX_CYCLES (MAXC),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc         (pc),
        .start      (start),
        .rearm      (rearm),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .cpu_freeze (cpu_freeze),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_last  (dump_last),
        .done       (done),
        .timed_out  (timed_out)
    );

    // CPU register file stand-in: rf[n] = 0x100 + n, read combinationally.
    assign reg_data = 32'h100 + {27'd0, reg_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] new_pc, input logic new_start,
                                 input logic new_rearm);
        pc    = new_pc;
        start = new_start;
        rearm = new_rearm;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        if (rand_ready) dump_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("done_reached", done, 1);
    endtask

    task automatic doRearm(input logic [31:0] hold_pc);
        applyStimulus(hold_pc, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(hold_pc, 1'b0, 1'b0);
        checkOutput("rearm_clears", {done, cpu_freeze, timed_out}, 3'b000);
    endtask

    // Model and per-cycle compare: outputs are checked mid-cycle, then the
    // model advances using the inputs that the next rising edge will see.
    always @(negedge clk) begin
        if (!rstn) begin
            checkOutput("reset_outputs",
                        {reg_sel, cpu_freeze, dump_data, dump_idx, dump_valid,
                         dump_last, done, timed_out}, 64'd0);
            exp_q.delete();
            m_run      = 1'b1;
            m_freeze   = 1'b0;
            m_done     = 1'b0;
            m_to       = 1'b0;
            m_cnt      = 0;
            prev_stall = 1'b0;
            cnt0_cycle = cyc + 1;
        end else begin
            was_done = m_done;
            checkOutput("cpu_freeze", cpu_freeze, m_freeze);
            checkOutput("done", done, m_done);
            checkOutput("timed_out", timed_out, m_to);
            checkOutput("no_spurious_valid", dump_valid && (exp_q.size() == 0), 0);
            if (prev_stall) begin
                checkOutput("stall_hold", {dump_valid, dump_last, dump_idx, dump_data},
                            prev_word);
            end
            if (dump_valid && dump_ready && exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                checkOutput("word_data", dump_data, exp_w.data);
                checkOutput("word_idx", dump_idx, exp_w.idx);
                checkOutput("word_last", dump_last, exp_w.last);
                captured[dump_idx] = dump_data;
                hs_count++;
                if (exp_q.size() == 0) begin
                    m_done     = 1'b1;
                    done_cycle = cyc + 1;
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_word  = {dump_valid, dump_last, dump_idx, dump_data};
            if (m_run) begin
                trig = (pc == HALT) || start || (m_cnt == MAXC - 1);
                if (trig) begin
                    m_run      = 1'b0;
                    m_freeze   = 1'b1;
                    m_to       = (pc != HALT) && !start;
                    trig_cycle = cyc;
                    exp_q.push_back('{data: pc, idx: 6'd0, last: 1'b0});
                    for (int r = 0; r < 32; r++) begin
                        exp_q.push_back('{data: (r == 0) ? 32'd0 : 32'h100 + r,
                                          idx: 6'(r + 1), last: (r == 31)});
                    end
                end else if (m_cnt < 65535) begin
                    m_cnt++;
                end
            end else if (was_done && rearm) begin
                m_run      = 1'b1;
                m_freeze   = 1'b0;
                m_done     = 1'b0;
                m_to       = 1'b0;
                m_cnt      = 0;
                cnt0_cycle = cyc + 1;
            end
        end
        cyc++;
    end

    initial begin
        int n;
        rstn       = 1'b0;
        dump_ready = 1'b1;
        applyStimulus(32'd0, 1'b0, 1'b0);

        // Reset state
        stepN(2);
        checkOutput("reset_literal", {done, cpu_freeze, dump_valid, timed_out}, 4'b0000);
        rstn = 1'b1;

        // Halt PC reached by stepping pc, consumer always ready
        hs_count = 0;
        for (int k = 0; k <= 32; k++) begin
            applyStimulus(32'(k * 4), 1'b0, 1'b0);
            stepCycle();
        end
        waitDone(100);
        checkOutput("done_latency", done_cycle - trig_cycle, 66);
        checkOutput("halt_timed_out", timed_out, 0);
        checkOutput("halt_header", captured[0], 32'h0000_0080);
        checkOutput("halt_r0", captured[1], 32'h0000_0000);
        checkOutput("halt_r1", captured[2], 32'h0000_0101);
        checkOutput("halt_r31", captured[32], 32'h0000_011F);
        checkOutput("halt_word_count", hs_count, 33);
        stepN(3);
        checkOutput("done_held", {done, cpu_freeze}, 2'b11);
        doRearm(32'd0);

        // Randomly stalling consumer
        rand_ready = 1'b1;
        hs_count   = 0;
        applyStimulus(HALT, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(32'd0, 1'b0, 1'b0);
        waitDone(600);
        rand_ready = 1'b0;
        dump_ready = 1'b1;
        checkOutput("stall_word_count", hs_count, 33);
        checkOutput("stall_header", captured[0], 32'h0000_0080);
        checkOutput("stall_r16", captured[17], 32'h0000_0110);
        doRearm(32'd0);

        // Timeout: pc never reaches the halt address
        applyStimulus(32'h44, 1'b0, 1'b0);
        waitDone(1200);
        checkOutput("timeout_flag", timed_out, 1);
        checkOutput("timeout_header", captured[0], 32'h0000_0044);
        checkOutput("timeout_cycle", trig_cycle - cnt0_cycle, 999);
        doRearm(32'h44);

        // Manual start, later pc match during the stream is ignored
        applyStimulus(32'h50, 1'b0, 1'b0);
        stepN(20);
        hs_count = 0;
        applyStimulus(32'h50, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(32'h50, 1'b0, 1'b0);
        stepN(10);
        applyStimulus(HALT, 1'b0, 1'b0);
        stepN(5);
        applyStimulus(32'h50, 1'b0, 1'b0);
        waitDone(200);
        stepN(5);
        checkOutput("start_header", captured[0], 32'h0000_0050);
        checkOutput("start_single_dump", hs_count, 33);
        checkOutput("start_timed_out", timed_out, 0);

        // Rearm then a second complete dump
        doRearm(32'h50);
        hs_count = 0;
        applyStimulus(HALT, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(32'h50, 1'b0, 1'b0);
        waitDone(200);
        checkOutput("second_dump_count", hs_count, 33);
        checkOutput("second_dump_r31", captured[32], 32'h0000_011F);
        doRearm(32'h50);

        // Reset during word idx 10, then counter restarts from zero
        applyStimulus(HALT, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(32'h44, 1'b0, 1'b0);
        n = 0;
        while (!(dump_valid && dump_idx == 6'd10) && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("idx10_reached", dump_valid && dump_idx == 6'd10, 1);
        rstn = 1'b0;
        #1;
        checkOutput("async_reset",
                    {reg_sel, cpu_freeze, dump_data, dump_idx, dump_valid,
                     dump_last, done, timed_out}, 64'd0);
        stepN(3);
        rstn = 1'b1;
        waitDone(1200);
        checkOutput("post_reset_timeout", timed_out, 1);
        checkOutput("post_reset_cycle", trig_cycle - cnt0_cycle, 999);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
